// File: rtl/frame_streamer_pkg.sv
// Shared post-processing definitions: pixel/coordinate widths, default frame
// geometry and the frame_streamer state encoding.
package frame_streamer_pkg;

  localparam int PIX_W      = 8;
  localparam int COORD_W    = 10;
  localparam int DEF_ROW_SZ = 320;
  localparam int DEF_COL_SZ = 240;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous pixel FIFO with occupancy count. Push when full and pop
// when empty are ignored; the streamer's credit scheme keeps both from
// happening.
module pix_fifo
  import frame_streamer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  pix_t             push_data,
  input  logic             pop,
  output pix_t             head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// Raster-order pixel source: reads one frame from a fixed-latency memory and
// emits value/x/y/valid, using a credit-limited skid FIFO so downstream stall
// never drops or repeats a pixel.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int ROW_SZ     = DEF_ROW_SZ,
  parameter int COL_SZ     = DEF_COL_SZ,
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  out_val,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic              is_out_val,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int LAST_ADDR = ROW_SZ * COL_SZ - 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT-1:0] inflight_sr;
  logic [CNT_W:0]    inflight_n;
  logic [CNT_W:0]    credit_used;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  pix_t              fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              issue;
  logic              ret_vld;
  logic              take;
  logic              last_out;
  pix_t              emit_data;
  coord_t            nx;
  coord_t            ny;

  // Count reads still travelling through the memory pipeline.
  always_comb begin
    inflight_n = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_n = inflight_n + {{CNT_W{1'b0}}, inflight_sr[i]};
    end
  end

  // A read is only issued if its data is guaranteed a FIFO slot on return.
  assign credit_used = {1'b0, fifo_count} + inflight_n;
  assign issue       = (state == ST_STREAM) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign mem_rd_en   = issue;
  assign mem_addr    = rd_addr;
  assign busy        = (state != ST_IDLE);

  // Returning data bypasses an empty FIFO straight into the output register,
  // which gives the first pixel at start+RD_LAT+2 and a gapless 1 pixel/cycle.
  assign ret_vld   = inflight_sr[RD_LAT-1];
  assign take      = !stall && (!fifo_empty || ret_vld);
  assign fifo_pop  = !stall && !fifo_empty;
  assign fifo_push = ret_vld && !(fifo_empty && !stall);
  assign emit_data = fifo_empty ? mem_rd_data : fifo_head;

  assign last_out = is_out_val && (out_x == COORD_W'(ROW_SZ - 1)) &&
                    (out_y == COORD_W'(COL_SZ - 1));

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mem_rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Frame FSM and read address counter; frame_done follows the last pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rd_addr    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_STREAM;
            rd_addr <= '0;
          end
        end
        ST_STREAM: begin
          if (issue) begin
            if (rd_addr == ADDR_W'(LAST_ADDR)) state <= ST_DRAIN;
            else                              rd_addr <= rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_out) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-latency tracker: a bit leaving the last stage marks valid memory data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inflight_sr <= '0;
    else        inflight_sr <= (inflight_sr << 1) | RD_LAT'(issue);
  end

  // Output register: emit one pixel per unstalled cycle, tagged with raster coordinates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val    <= '0;
      out_x      <= '0;
      out_y      <= '0;
      is_out_val <= 1'b0;
      nx         <= '0;
      ny         <= '0;
    end else begin
      is_out_val <= take;
      if (state == ST_IDLE && start) begin
        nx    <= '0;
        ny    <= '0;
        out_x <= '0;
        out_y <= '0;
      end else if (take) begin
        out_val <= emit_data;
        out_x   <= nx;
        out_y   <= ny;
        if (nx == COORD_W'(ROW_SZ - 1)) begin
          nx <= '0;
          ny <= (ny == COORD_W'(COL_SZ - 1)) ? '0 : ny + 1'b1;
        end else begin
          nx <= nx + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Raster-order pixel source for the post-processing chain. On a start pulse it reads one ROW_SZ×COL_SZ 8-bit frame from a fixed-latency frame memory and emits it as the `value / x / y / valid` pixel stream consumed by `median_filt` and the other post-proc filters. A small credit-controlled FIFO absorbs memory read latency so that a downstream `stall` never loses or duplicates a pixel.

## Interface
- ROW_SZ, 320, pixels per row
- COL_SZ, 240, rows per frame
- RD_LAT, 2, memory read latency in cycles (1..2)
- ADDR_W, 17, memory address width (must satisfy 2^ADDR_W ≥ ROW_SZ*COL_SZ)
- FIFO_DEPTH, 4, skid FIFO entries (must be ≥ RD_LAT+2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- stall  in  1  downstream hold; no pixel is emitted on the cycle after stall is high
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address, row-major (y*ROW_SZ + x)
- mem_rd_data  in  8  read data, valid RD_LAT cycles after mem_rd_en
- out_val  out  8  pixel value
- out_x  out  10  pixel column
- out_y  out  10  pixel row
- is_out_val  out  1  single-cycle pixel strobe
- busy  out  1  high from STREAM entry until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel is emitted

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: start=1 → STREAM; rd address counter, out_x, and out_y are cleared. Start is ignored outside IDLE.
- STREAM: issue a read (mem_rd_en=1) when fifo_count + inflight < FIFO_DEPTH. The address increments on each issue. Issuing address ROW_SZ*COL_SZ-1 → DRAIN on the same edge.
- DRAIN: no reads. When the last pixel (x=ROW_SZ-1, y=COL_SZ-1) is emitted, go to IDLE and pulse frame_done on the following cycle.
- Inflight tracking: RD_LAT-stage valid shift register. When a stage-RD_LAT bit emerges, mem_rd_data is pushed into the FIFO.
- Output register: on each edge, if !stall and FIFO non-empty, pop the head into out_val and set is_out_val=1. Otherwise is_out_val=0 and out_val holds its value.
- Coordinates are tagged at emission from out_x/out_y counters:
  - out_x increments per emitted pixel and wraps ROW_SZ-1 → 0.
  - out_y increments on that wrap.
- Push and pop in the same cycle leave fifo_count unchanged. The credit rule guarantees the FIFO never overflows; an overflow is a design error, and the bench asserts on it.
- Reset (any time, including mid-frame): state=IDLE, FIFO and inflight cleared. Data returned by the memory after reset is discarded.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, out_val=0, out_x=0, out_y=0, is_out_val=0, busy=0, frame_done=0.
- Start sampled at edge 0:
  - STREAM, busy=1, and first mem_rd_en with addr 0 in cycle 1.
  - Data pushed at edge 1+RD_LAT.
  - First is_out_val in cycle 2+RD_LAT, with x=0, y=0.
- Unstalled throughput: 1 pixel/cycle. A frame takes ROW_SZ*COL_SZ + RD_LAT + 2 cycles from start to frame_done.
- Stall at edge n suppresses the pixel in cycle n+1. Reads pause after at most FIFO_DEPTH outstanding. Release resumes 1 pixel/cycle with no gap beyond the stall itself.
- is_out_val is never high for two cycles carrying the same pixel. out_x/out_y/out_val are stable whenever is_out_val=0.

## Structure
- Shared post-proc package: pixel width (8), coordinate width (10), default ROW_SZ/COL_SZ, and the state encoding localparams.
- One sub-module, `pix_fifo`: synchronous FIFO, width 8, depth FIFO_DEPTH, with push/pop/count/empty. Uses the same asynchronous active-low reset.
- Top level holds the FSM, address counter, inflight shift register, credit compare, and coordinate counters.

## Test plan
Bench parameters: ROW_SZ=4, COL_SZ=3, RD_LAT=2; memory model returns addr+0x10.
- Free run: start, stall=0 → 12 consecutive is_out_val pulses starting 4 cycles after start, with values 0x10..0x1B and (x,y) from (0,0) to (3,2). frame_done is high exactly one cycle after the last pixel; busy falls at the same time.
- Stall storm: stall high for cycles 5–12 → no pixel lost or repeated, mem_rd_en pauses with ≤4 outstanding, and the sequence is identical to free run.
- Random stall: 50% random stall over 10 frames → scoreboard matches value and coordinates; no FIFO overflow assertion fires.
- Start while busy: a second start at cycle 6 → ignored; exactly 12 pixels and one frame_done.
- Reset mid-frame: reset low at pixel 5 → all outputs 0 in the reset cycle. A late memory return is not emitted. A fresh start then yields pixel (0,0)=0x10.
- Back-to-back frames: start on the cycle after frame_done → second frame restarts at (0,0) with no stale data.
